icache: RTL and testbench

Direct-mapped instruction cache between the instruction-fetch stage and the memory controller. Serves 32-bit instructions to the fetch stage in one cycle on a hit. On a miss, requests a full 64-byte line from the memory controller's line-fetch port, fills the line, then returns the instruction.

---
 rtl/icache.sv | 138 +++++++++++++
 tb/tb_icache.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// Direct-mapped instruction cache: 1-cycle hits, 64-byte line refill on a miss.
// Optional hit/miss performance counters are built when ICACHE_PERF_EN is defined.
module icache #(
  parameter int LINE_NUM = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         fetch_valid,
  input  logic [31:0]  fetch_pc,
  input  logic         flush,
  output logic         fetch_ready,
  output logic [31:0]  fetch_inst,
  output logic         mem_en,
  output logic [31:0]  mem_pc,
  input  logic         mem_done,
  input  logic [511:0] mem_data
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]  hit_cnt,
  output logic [31:0]  miss_cnt
`endif
);

  localparam int IDX_W = $clog2(LINE_NUM);
  localparam int TAG_W = 26 - IDX_W;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_drop, w_drop_nxt;
  logic [31:2]         r_pc;
  logic [LINE_NUM-1:0] r_valid;
  logic [TAG_W-1:0]    r_tag  [LINE_NUM];
  logic [511:0]        r_data [LINE_NUM];

  logic [IDX_W-1:0]    w_req_idx, w_fill_idx;
  logic [TAG_W-1:0]    w_req_tag;
  logic                w_hit, w_acc_hit, w_acc_miss, w_fill, w_resp;
  logic                w_unused;

  function automatic logic [31:0] f_word(input logic [511:0] line, input logic [3:0] w);
    return line[32*w +: 32];
  endfunction

  assign w_req_idx  = fetch_pc[6 +: IDX_W];
  assign w_req_tag  = fetch_pc[31 -: TAG_W];
  assign w_fill_idx = r_pc[6 +: IDX_W];
  assign w_hit      = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);
  assign w_unused   = ^fetch_pc[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_drop  <= w_drop_nxt;
    end
  end

  // A flush coinciding with mem_done suppresses that response as well.
  always_comb begin
    w_state_nxt = r_state;
    w_drop_nxt  = r_drop;
    w_acc_hit   = 1'b0;
    w_acc_miss  = 1'b0;
    w_fill      = 1'b0;
    w_resp      = 1'b0;
    if (rdy) begin
      case (r_state)
        S_IDLE: begin
          if (fetch_valid && !flush) begin
            if (w_hit) begin
              w_acc_hit = 1'b1;
            end else begin
              w_acc_miss  = 1'b1;
              w_state_nxt = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (flush) w_drop_nxt = 1'b1;
          if (mem_done) begin
            w_fill      = 1'b1;
            w_resp      = !(r_drop || flush);
            w_drop_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_ready <= 1'b0;
      fetch_inst  <= '0;
      mem_en      <= 1'b0;
      mem_pc      <= '0;
      r_valid     <= '0;
    end else if (rdy) begin
      fetch_ready <= w_acc_hit | w_resp;
      if (w_acc_hit)   fetch_inst <= f_word(r_data[w_req_idx], fetch_pc[5:2]);
      else if (w_resp) fetch_inst <= f_word(mem_data, r_pc[5:2]);
      if (w_acc_miss) begin
        mem_en <= 1'b1;
        mem_pc <= {fetch_pc[31:6], 6'b0};
      end else if (w_fill) begin
        mem_en <= 1'b0;
      end
      if (w_fill) r_valid[w_fill_idx] <= 1'b1;
    end
  end

  // Line storage and miss address carry no reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (w_acc_miss) r_pc <= fetch_pc[31:2];
    if (w_fill) begin
      r_data[w_fill_idx] <= mem_data;
      r_tag[w_fill_idx]  <= r_pc[31 -: TAG_W];
    end
  end

`ifdef ICACHE_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (w_acc_hit)  hit_cnt  <= hit_cnt + 32'd1;
      if (w_acc_miss) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache.sv
// Bench for icache: transaction-level cache model, line-fill responder and directed scenarios.
module tb_icache;
  localparam int LN  = 16;
  localparam int LAT = 20;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rdy = 1'b1;
  logic         fetch_valid = 1'b0;
  logic [31:0]  fetch_pc = '0;
  logic         flush = 1'b0;
  logic         fetch_ready;
  logic [31:0]  fetch_inst;
  logic         mem_en;
  logic [31:0]  mem_pc;
  logic         mem_done = 1'b0;
  logic [511:0] mem_data = '0;
`ifdef ICACHE_PERF_EN
  logic [31:0]  hit_cnt, miss_cnt;
`endif

  icache #(.LINE_NUM(LN)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .flush(flush),
    .fetch_ready(fetch_ready), .fetch_inst(fetch_inst),
    .mem_en(mem_en), .mem_pc(mem_pc), .mem_done(mem_done), .mem_data(mem_data)
`ifdef ICACHE_PERF_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  // Backing memory: byte at address a is its line offset plus 3 * (line number - 0x40).
  function automatic logic [7:0] mbyte(input logic [31:0] a);
    logic [31:0] ln;
    ln = a >> 6;
    return 8'((a & 32'd63) + (ln - 32'h40) * 32'd3);
  endfunction

  function automatic logic [31:0] mword(input logic [31:0] a);
    logic [31:0] b;
    b = a & ~32'd3;
    return {mbyte(b + 32'd3), mbyte(b + 32'd2), mbyte(b + 32'd1), mbyte(b)};
  endfunction

  function automatic logic [511:0] mline(input logic [31:0] a);
    logic [511:0] l;
    for (int k = 0; k < 64; k++) l[8*k +: 8] = mbyte((a & ~32'd63) + 32'(k));
    return l;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", nm, act, exp, $time);
    end
  endtask

  // Line-fetch responder: after LAT cycles of mem_en, pulse mem_done with the line.
  int mc_cnt = 0;
  always @(negedge clk) begin
    if (mem_done) begin
      mem_done = 1'b0;
    end else if (!mem_en) begin
      mc_cnt = 0;
    end else if (mc_cnt > 0) begin
      mc_cnt--;
      if (mc_cnt == 0) begin
        mem_data = mline(mem_pc);
        mem_done = 1'b1;
      end
    end else begin
      mc_cnt = LAT;
    end
  end

  // Reference model: cache contents tracked by full line number per index.
  bit          m_valid [LN];
  logic [31:0] m_line  [LN];
  bit          m_wait, m_drop;
  logic [31:0] m_pc;
  int          mix;
  logic        e_ready, e_men;
  logic [31:0] e_inst, e_mpc;
  logic [31:0] m_hits, m_misses;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LN; i++) m_valid[i] = 1'b0;
      m_wait = 0; m_drop = 0;
      e_ready = 0; e_men = 0; e_inst = '0; e_mpc = '0;
      m_hits = '0; m_misses = '0;
    end else if (rdy) begin
      e_ready = 1'b0;
      if (!m_wait) begin
        if (fetch_valid && !flush) begin
          mix = int'((fetch_pc >> 6) & 32'(LN - 1));
          if (m_valid[mix] && m_line[mix] == (fetch_pc >> 6)) begin
            e_ready = 1'b1;
            e_inst  = mword(fetch_pc);
            m_hits++;
          end else begin
            m_wait = 1'b1;
            m_pc   = fetch_pc;
            e_men  = 1'b1;
            e_mpc  = fetch_pc & ~32'd63;
            m_misses++;
          end
        end
      end else begin
        if (flush) m_drop = 1'b1;
        if (mem_done) begin
          mix = int'((m_pc >> 6) & 32'(LN - 1));
          m_valid[mix] = 1'b1;
          m_line[mix]  = m_pc >> 6;
          e_men = 1'b0;
          if (!m_drop) begin
            e_ready = 1'b1;
            e_inst  = mword(m_pc);
          end
          m_drop = 1'b0;
          m_wait = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("cyc_ready", 32'(fetch_ready), 32'(e_ready));
      chk("cyc_inst", fetch_inst, e_inst);
      chk("cyc_mem_en", 32'(mem_en), 32'(e_men));
      chk("cyc_mem_pc", mem_pc, e_mpc);
`ifdef ICACHE_PERF_EN
      chk("cyc_hit_cnt", hit_cnt, m_hits);
      chk("cyc_miss_cnt", miss_cnt, m_misses);
`endif
    end
  end

  task automatic issue(input logic [31:0] pc);
    @(negedge clk);
    fetch_valid = 1'b1;
    fetch_pc    = pc;
    @(negedge clk);
    fetch_valid = 1'b0;
  endtask

  task automatic wait_ready(input string nm, input int maxc);
    int n;
    n = 0;
    while (!fetch_ready && n < maxc) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!fetch_ready) begin
      errors++;
      $display("FAIL %s timeout actual=0 required=1 after %0d cycles", nm, n);
    end
  endtask

  initial begin
    int n, nr;
    repeat (2) @(negedge clk);
    cmp_on = 1'b1;
    chk("rst_ready", 32'(fetch_ready), 32'd0);
    chk("rst_inst", fetch_inst, 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_pc", mem_pc, 32'd0);
    rst = 1'b0;

    // Cold miss then refill.
    issue(32'h0000_1004);
    chk("cold_mem_en", 32'(mem_en), 32'd1);
    chk("cold_mem_pc", mem_pc, 32'h0000_1000);
    wait_ready("cold_fill", 100);
    chk("cold_inst", fetch_inst, 32'h0706_0504);
    chk("cold_men_drop", 32'(mem_en), 32'd0);

    // Same-line hit.
    issue(32'h0000_103C);
    chk("hit_ready", 32'(fetch_ready), 32'd1);
    chk("hit_inst", fetch_inst, 32'h3F3E_3D3C);
    chk("hit_mem_en", 32'(mem_en), 32'd0);

    // Back-to-back hits, one response per cycle.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) chk("b2b_ready", 32'(fetch_ready), 32'd1);
      fetch_valid = 1'b1;
      fetch_pc    = 32'h0000_1000 + 32'(4 * i);
    end
    @(negedge clk);
    fetch_valid = 1'b0;
    chk("b2b_ready_last", 32'(fetch_ready), 32'd1);
    chk("b2b_inst_last", fetch_inst, 32'h0F0E_0D0C);

    // Conflict eviction on index 0.
    issue(32'h0000_1400);
    chk("evict_mem_en", 32'(mem_en), 32'd1);
    chk("evict_mem_pc", mem_pc, 32'h0000_1400);
    wait_ready("evict_fill", 100);
    chk("evict_inst", fetch_inst, 32'h3332_3130);
    issue(32'h0000_1000);
    chk("remiss_mem_en", 32'(mem_en), 32'd1);
    chk("remiss_mem_pc", mem_pc, 32'h0000_1000);
    wait_ready("remiss_fill", 100);

    // Flush during WAIT: refill completes silently, line is usable afterwards.
    issue(32'h0000_2000);
    chk("flush_mem_en", 32'(mem_en), 32'd1);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n = 0; nr = 0;
    while (mem_en && n < 100) begin
      @(negedge clk);
      n++;
      if (fetch_ready) nr++;
    end
    chk("flush_no_ready", 32'(nr), 32'd0);
    chk("flush_men_drop", 32'(mem_en), 32'd0);
    issue(32'h0000_2008);
    chk("flush_hit_ready", 32'(fetch_ready), 32'd1);
    chk("flush_hit_inst", fetch_inst, 32'hCBCA_C9C8);

    // Reset in the middle of a miss.
    issue(32'h0000_3000);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_mem_en", 32'(mem_en), 32'd0);
    chk("rstmid_ready", 32'(fetch_ready), 32'd0);
    issue(32'h0000_3000);
    chk("rstmid_remiss", 32'(mem_en), 32'd1);
    wait_ready("rstmid_fill", 100);

    // rdy stall holds the hit response; a request during rdy=0 is lost.
    @(negedge clk);
    fetch_valid = 1'b1;
    fetch_pc    = 32'h0000_3004;
    @(negedge clk);
    fetch_valid = 1'b0;
    rdy = 1'b0;
    chk("stall_inst", fetch_inst, 32'h8786_8584);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_hold", 32'(fetch_ready), 32'd1);
    end
    rdy = 1'b1;
    @(negedge clk);
    chk("stall_release", 32'(fetch_ready), 32'd0);
    rdy = 1'b0;
    fetch_valid = 1'b1;
    fetch_pc    = 32'h0000_5000;
    @(negedge clk);
    fetch_valid = 1'b0;
    rdy = 1'b1;
    repeat (3) @(negedge clk);
    chk("lost_mem_en", 32'(mem_en), 32'd0);
    chk("lost_ready", 32'(fetch_ready), 32'd0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
